motion_bbox_tracker: RTL and testbench

Downstream stage of the motion-detection pipeline: drains the highlighted-frame output FIFO, counts motion pixels (those equal to the highlight colour) and tracks the bounding box of motion for each frame. It reports per-frame statistics with a one-cycle valid pulse. It can optionally forward every pixel unchanged into a further output FIFO, for display or write-back.

---
 rtl/motion_pkg.sv | 28 ++
 rtl/pixel_coord_counter.sv | 39 +++
 rtl/motion_bbox_tracker.sv | 158 +++++++++++++++
 tb/tb_motion_bbox_tracker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared constants, FSM state type and width helpers for the motion bounding-box tracker.
package motion_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 24;
  localparam int unsigned IMG_WIDTH_DEF    = 720;
  localparam int unsigned IMG_HEIGHT_DEF   = 540;
  localparam logic [23:0] MOTION_COLOR_DEF = 24'hFF0000;

  typedef enum logic {
    S_SCAN   = 1'b0,
    S_REPORT = 1'b1
  } state_t;

  // Coordinate width; a one-entry dimension still gets one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Count width large enough to hold a full frame of motion pixels.
  function automatic int unsigned cnt_w(input int unsigned w, input int unsigned h);
    return $clog2(w * h + 1);
  endfunction

  localparam int unsigned X_W_DEF   = idx_w(IMG_WIDTH_DEF);
  localparam int unsigned Y_W_DEF   = idx_w(IMG_HEIGHT_DEF);
  localparam int unsigned CNT_W_DEF = cnt_w(IMG_WIDTH_DEF, IMG_HEIGHT_DEF);

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster x/y position of the next pixel to be popped; wraps at the end of each line and frame.
module pixel_coord_counter
  import motion_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  localparam int unsigned X_W = idx_w(IMG_WIDTH),
  localparam int unsigned Y_W = idx_w(IMG_HEIGHT)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_pixel
);

  logic x_last;
  logic y_last;

  assign x_last     = (x == X_W'(IMG_WIDTH - 1));
  assign y_last     = (y == Y_W'(IMG_HEIGHT - 1));
  assign last_pixel = x_last && y_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/motion_bbox_tracker.sv
// Counts motion-coloured pixels per frame and tracks their bounding box.
// MOTION_BBOX_PASSTHROUGH_EN forwards every popped pixel to the downstream FIFO.
module motion_bbox_tracker
  import motion_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter logic [DATA_WIDTH-1:0] MOTION_COLOR = DATA_WIDTH'(MOTION_COLOR_DEF),
  localparam int unsigned CNT_W = cnt_w(IMG_WIDTH, IMG_HEIGHT),
  localparam int unsigned X_W   = idx_w(IMG_WIDTH),
  localparam int unsigned Y_W   = idx_w(IMG_HEIGHT)
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  stats_valid,
  output logic                  motion_detected,
  output logic [CNT_W-1:0]      motion_count,
  output logic [X_W-1:0]        x_min,
  output logic [X_W-1:0]        x_max,
  output logic [Y_W-1:0]        y_min,
  output logic [Y_W-1:0]        y_max
);

  state_t           state, state_nxt;
  logic             stall_c, pop, hit, last_pixel;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             seen, seen_nxt;
  logic [CNT_W-1:0] cnt_acc, cnt_nxt;
  logic [X_W-1:0]   xmin_acc, xmax_acc, xmin_nxt, xmax_nxt;
  logic [Y_W-1:0]   ymin_acc, ymax_acc, ymin_nxt, ymax_nxt;

`ifdef MOTION_BBOX_PASSTHROUGH_EN
  assign stall_c   = in_empty || out_full;
  assign out_wr_en = in_rd_en;
  assign out_din   = in_dout;
`else
  logic unused_out_full;
  assign unused_out_full = out_full;
  assign stall_c   = in_empty;
  assign out_wr_en = 1'b0;
  assign out_din   = '0;
`endif

  assign pop = in_rd_en;
  assign hit = pop && (in_dout == MOTION_COLOR);

  pixel_coord_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_coord (
    .clock      (clock),
    .reset      (reset),
    .advance    (pop),
    .x          (x),
    .y          (y),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_SCAN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rd_en  = 1'b0;
    case (state)
      S_SCAN: begin
        in_rd_en = !stall_c;
        if (!stall_c && last_pixel) state_nxt = S_REPORT;
      end
      S_REPORT: state_nxt = S_SCAN;
      default:  state_nxt = S_SCAN;
    endcase
  end

  // Accumulator update including the pixel popped this cycle.
  always_comb begin
    seen_nxt = seen;
    cnt_nxt  = cnt_acc;
    xmin_nxt = xmin_acc;
    xmax_nxt = xmax_acc;
    ymin_nxt = ymin_acc;
    ymax_nxt = ymax_acc;
    if (hit) begin
      seen_nxt = 1'b1;
      cnt_nxt  = cnt_acc + CNT_W'(1);
      if (!seen) begin
        xmin_nxt = x;
        xmax_nxt = x;
        ymin_nxt = y;
        ymax_nxt = y;
      end else begin
        if (x < xmin_acc) xmin_nxt = x;
        if (x > xmax_acc) xmax_nxt = x;
        if (y < ymin_acc) ymin_nxt = y;
        if (y > ymax_acc) ymax_nxt = y;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seen     <= 1'b0;
      cnt_acc  <= '0;
      xmin_acc <= '0;
      xmax_acc <= '0;
      ymin_acc <= '0;
      ymax_acc <= '0;
    end else if (state == S_REPORT) begin
      seen     <= 1'b0;
      cnt_acc  <= '0;
      xmin_acc <= '0;
      xmax_acc <= '0;
      ymin_acc <= '0;
      ymax_acc <= '0;
    end else if (pop) begin
      seen     <= seen_nxt;
      cnt_acc  <= cnt_nxt;
      xmin_acc <= xmin_nxt;
      xmax_acc <= xmax_nxt;
      ymin_acc <= ymin_nxt;
      ymax_acc <= ymax_nxt;
    end
  end

  // Published on the final pop so the stats are visible during S_REPORT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stats_valid     <= 1'b0;
      motion_detected <= 1'b0;
      motion_count    <= '0;
      x_min           <= '0;
      x_max           <= '0;
      y_min           <= '0;
      y_max           <= '0;
    end else begin
      stats_valid <= pop && last_pixel;
      if (pop && last_pixel) begin
        motion_detected <= seen_nxt;
        motion_count    <= cnt_nxt;
        x_min           <= xmin_nxt;
        x_max           <= xmax_nxt;
        y_min           <= ymin_nxt;
        y_max           <= ymax_nxt;
      end
    end
  end

endmodule

// File: tb/tb_motion_bbox_tracker.sv
// Directed self-checking bench for motion_bbox_tracker on a 4x3 frame.
module tb_motion_bbox_tracker;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned N  = W * H;
  localparam int unsigned DW = 24;
  localparam int unsigned CW = 4;
  localparam int unsigned XW = 2;
  localparam int unsigned YW = 2;
  localparam logic [DW-1:0] MC = 24'hFF0000;

  logic          clock;
  logic          reset;
  logic          in_rd_en;
  logic          in_empty;
  logic [DW-1:0] in_dout;
  logic          out_wr_en;
  logic [DW-1:0] out_din;
  logic          out_full;
  logic          stats_valid;
  logic          motion_detected;
  logic [CW-1:0] motion_count;
  logic [XW-1:0] x_min, x_max;
  logic [YW-1:0] y_min, y_max;

  int errors = 0;
  int checks = 0;

  motion_bbox_tracker #(
    .DATA_WIDTH   (DW),
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .MOTION_COLOR (MC)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_rd_en        (in_rd_en),
    .in_empty        (in_empty),
    .in_dout         (in_dout),
    .out_wr_en       (out_wr_en),
    .out_din         (out_din),
    .out_full        (out_full),
    .stats_valid     (stats_valid),
    .motion_detected (motion_detected),
    .motion_count    (motion_count),
    .x_min           (x_min),
    .x_max           (x_max),
    .y_min           (y_min),
    .y_max           (y_max)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one pixel until it is popped; returns #1 after the popping edge.
  task automatic push_px(input logic [DW-1:0] d);
    logic popped;
    int   n;
    popped   = 1'b0;
    n        = 0;
    in_empty = 1'b0;
    in_dout  = d;
    while (!popped && n < 20) begin
      @(negedge clock);
      popped = in_rd_en;
      if (popped) begin
        check("no_stats_during_scan", stats_valid, 0);
`ifdef MOTION_BBOX_PASSTHROUGH_EN
        check("pass_wr_en", out_wr_en, 1);
        check("pass_din", out_din, d);
`else
        check("sink_wr_en", out_wr_en, 0);
        check("sink_din", out_din, 0);
`endif
      end
      @(posedge clock);
      #1;
      n++;
    end
    check("pixel_popped", popped, 1);
    in_empty = 1'b1;
  endtask

  // Raster pixels lo..hi: motion where mask bit set, otherwise bg.
  task automatic send_range(input logic [N-1:0] mask, input logic [DW-1:0] bg,
                            input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push_px(mask[i] ? MC : bg);
  endtask

  task automatic check_stats(input string tag, input logic det, input int cnt,
                             input int x0, input int x1, input int y0, input int y1);
    check({tag, "_valid"}, stats_valid, 1);
    check({tag, "_det"},   motion_detected, 32'(det));
    check({tag, "_cnt"},   motion_count, cnt);
    check({tag, "_xmin"},  x_min, x0);
    check({tag, "_xmax"},  x_max, x1);
    check({tag, "_ymin"},  y_min, y0);
    check({tag, "_ymax"},  y_max, y1);
  endtask

  initial begin
    reset    = 1'b0;
    in_empty = 1'b1;
    in_dout  = '0;
    out_full = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_rd_en", in_rd_en, 0);
    check("rst_wr_en", out_wr_en, 0);
    check("rst_din", out_din, 0);
    check("rst_valid", stats_valid, 0);
    check("rst_det", motion_detected, 0);
    check("rst_cnt", motion_count, 0);
    check("rst_box", {x_min, x_max, y_min, y_max}, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Motion at (1,0) and (2,2); near-miss background exercises full-width compare.
    send_range(12'h402, 24'hFF0001, 0, N - 1);
    check_stats("frame_a", 1'b1, 2, 1, 2, 0, 2);
    @(posedge clock);
    #1;
    check("pulse_one_cycle", stats_valid, 0);
    check("hold_cnt", motion_count, 2);
    check("hold_xmax", x_max, 2);

    send_range(12'h000, 24'h000000, 0, N - 1);
    check_stats("zero", 1'b0, 0, 0, 0, 0, 0);

    // Back-to-back frames: all motion, then only (3,1).
    send_range(12'hFFF, 24'h00FF00, 0, N - 1);
    check_stats("all", 1'b1, 12, 0, 3, 0, 2);
    send_range(12'h080, 24'h7F0000, 0, N - 1);
    check_stats("single", 1'b1, 1, 3, 3, 1, 1);

`ifdef MOTION_BBOX_PASSTHROUGH_EN
    // Downstream full for 5 cycles with a motion pixel waiting at the head.
    send_range(12'h402, 24'h0000FF, 0, 4);
    out_full = 1'b1;
    in_empty = 1'b0;
    in_dout  = MC;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("stall_rd_en", in_rd_en, 0);
      check("stall_wr_en", out_wr_en, 0);
      @(posedge clock);
      #1;
    end
    out_full = 1'b0;
    send_range(12'h402, 24'h0000FF, 5, N - 1);
    check_stats("stalled", 1'b1, 2, 1, 2, 0, 2);
`else
    // Sink build ignores out_full entirely.
    out_full = 1'b1;
    send_range(12'h402, 24'h0000FF, 0, N - 1);
    check_stats("full_ignored", 1'b1, 2, 1, 2, 0, 2);
    out_full = 1'b0;
`endif

    // Partial frame of 6 motion pixels discarded by reset.
    send_range(12'h03F, 24'h000000, 0, 5);
    reset = 1'b0;
    #1;
    check("midrst_valid", stats_valid, 0);
    check("midrst_cnt", motion_count, 0);
    check("midrst_det", motion_detected, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    send_range(12'h801, 24'h123456, 0, N - 1);
    check_stats("after_rst", 1'b1, 2, 0, 3, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
